// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The optional feature is controlled by DMEM_ALIGN_CHECK_EN (see dmem_responder).
package dmem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_LANES    = 4;
  localparam int unsigned DMEM_WAIT_MAX = 15;
  localparam int unsigned CNT_W         = $clog2(DMEM_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic              we;
    logic              byte_acc;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  // Byte-lane write mask for a store: one lane for byte access, all lanes for word.
  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic byte_acc,
                                                      input logic [1:0] lane);
    logic [BYTE_LANES-1:0] m;
    m = '1;
    if (byte_acc) begin
      m = BYTE_LANES'(1) << lane;
    end
    return m;
  endfunction

  // Little-endian byte extraction, zero-extended to a full word.
  function automatic logic [WORD_W-1:0] lane_zext(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{(WORD_W-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with byte-lane write enables and read-first
// registered read data. Contents are not affected by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic [BYTE_LANES-1:0]          i_wbe,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [WORD_W-1:0]              i_wdata,
  output logic [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Read and lane-masked write share the single port on an enabled cycle.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (i_wbe[l]) begin
          r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: valid/ready request, fixed wait states, RAM access,
// valid/ready response. Define DMEM_ALIGN_CHECK_EN to fault misaligned word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned LIM_W  = WORD_W + 1;
  localparam logic [LIM_W-1:0] ADDR_LIMIT = LIM_W'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] CNT_INIT   =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  dmem_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  dmem_req_t         r_req, w_req_in, w_acc;
  logic              w_accept, w_commit, w_hs;
  logic              w_err, w_misalign, w_ram_en;
  logic [AW-1:0]     w_idx;
  logic [BYTE_LANES-1:0] w_wbe;
  logic [WORD_W-1:0] w_wdata, w_ram_q;

  logic              r_req_ready, r_rsp_valid, r_err;
  logic              r_rd_load, r_rd_byte;
  logic [1:0]        r_rd_lane;

  assign w_req_in = '{we: req_we, byte_acc: req_byte, addr: req_addr, wdata: req_wdata};

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero-wait commits use the live request; otherwise the captured one.
  always_comb begin
    w_acc = (r_state == IDLE) ? w_req_in : r_req;
    w_idx = w_acc.addr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    w_misalign = !w_acc.byte_acc && (w_acc.addr[1:0] != 2'd0);
`else
    w_misalign = 1'b0;
`endif
    w_err    = ({1'b0, w_acc.addr} >= ADDR_LIMIT) || w_misalign;
    w_ram_en = w_commit && !reset;
    w_wbe    = (w_acc.we && !w_err) ? lane_mask(w_acc.byte_acc, w_acc.addr[1:0]) : '0;
    w_wdata  = w_acc.byte_acc ? {BYTE_LANES{w_acc.wdata[7:0]}} : w_acc.wdata;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req <= w_req_in;
    end
  end

  // Registered handshake flags and response formatting controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rd_load   <= 1'b0;
      r_rd_byte   <= 1'b0;
      r_rd_lane   <= 2'd0;
    end else begin
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_commit) begin
        r_err     <= w_err;
        r_rd_load <= !w_acc.we && !w_err;
        r_rd_byte <= w_acc.byte_acc;
        r_rd_lane <= w_acc.addr[1:0];
      end else if (w_hs) begin
        r_err     <= 1'b0;
        r_rd_load <= 1'b0;
        r_rd_byte <= 1'b0;
        r_rd_lane <= 2'd0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_wbe   (w_wbe),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_q)
  );

  // RAM read register holds until the next commit, so the formatted data is stable in RESP.
  assign rsp_rdata = r_rd_load ? (r_rd_byte ? lane_zext(w_ram_q, r_rd_lane) : w_ram_q)
                               : '0;
  assign rsp_err   = r_err;
  assign rsp_valid = r_rsp_valid;
  assign req_ready = r_req_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic
// compared against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory held as words.
  function automatic void model(input logic we, input logic byt, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output logic err);
    int unsigned idx, sh;
    err = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    if (!byt && (addr % 4) != 0) err = 1'b1;
`endif
    rd  = '0;
    idx = (addr / 4) % DEPTH;
    sh  = 8 * (addr % 4);
    if (!err) begin
      if (we) begin
        if (byt) mem_m[idx] = (mem_m[idx] & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        else     mem_m[idx] = wdata;
      end else begin
        rd = byt ? ((mem_m[idx] >> sh) & 32'hFF) : mem_m[idx];
      end
    end
  endfunction

  // One full transaction: accept, wait-state timing, response, optional stall, handshake.
  task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] got);
    logic [31:0] erd;
    logic        eerr;
    model(we, byt, addr, wdata, erd, eerr);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Junk request while busy must be ignored.
    req_we = 1'b1; req_byte = 1'b0; req_addr = $urandom_range(0, 1023); req_wdata = $urandom;
    for (int i = 0; i < WS; i++) begin
      chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
      chk("req_ready_wait", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    got = rsp_rdata;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, erd);
      chk("hold_err", 32'(rsp_err), 32'(eerr));
    end
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_rdata", rsp_rdata, 32'd0);
    chk("post_hs_err", 32'(rsp_err), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, d;
    logic        w, b;
    int          r;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_req(1'b1, 1'b0, 32'(i * 4), $urandom, 0, got);
    end

    do_req(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 0, got);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 0, got);
    chk("word_load_40", got, 32'hDEADBEEF);
    do_req(1'b1, 1'b1, 32'h41, 32'h000000AA, 0, got);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 0, got);
    chk("after_byte_store", got, 32'hDEADAAEF);
    do_req(1'b0, 1'b1, 32'h43, 32'h0, 0, got);
    chk("byte_load_43", got, 32'h000000DE);

    // Out of range: fault, no write (0x400 aliases word 0 in the index bits).
    do_req(1'b0, 1'b0, 32'h400, 32'h0, 0, got);
    do_req(1'b1, 1'b0, 32'h400, 32'h13579BDF, 0, got);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 0, got);

    // Stall in RESP for 3 cycles.
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 3, got);
    chk("stall_data", got, 32'hDEADAAEF);

    // Reset during WAIT aborts an uncommitted store.
    do_req(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 0, got);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 32'h80; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("abort");
    reset = 1'b0;
    do_req(1'b0, 1'b0, 32'h80, 32'h0, 0, got);
    chk("abort_old_data", got, 32'hCAFEF00D);

    // Misaligned word store.
    do_req(1'b1, 1'b0, 32'h42, 32'h55AA55AA, 0, got);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 0, got);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misaligned_store", got, 32'hDEADAAEF);
`else
    chk("misaligned_store", got, 32'h55AA55AA);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 4095));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 1023));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      d = $urandom;
      do_req(w, b, a, d, $urandom_range(0, 3), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the datapath's load/store path. It accepts the ALU-computed byte address, plus write data and control, through a valid/ready request channel. After a fixed number of wait states it performs a word or byte access on an internal RAM and returns read data and an error flag through a valid/ready response channel. Every load and store from the execute stage terminates here, so it models a slow data memory the core must stall on.

## Interface
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words; power of two, ≥4.
- `WAIT_STATES`, default 2: cycles between request accept and access commit; range 0–15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_addr` in 32: byte address, from ALU result.
- `req_wdata` in 32: store data; byte stores use bits [7:0].
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts response.
- `rsp_rdata` out 32: load data; 0 for stores and errors.
- `rsp_err` out 1: access faulted; no RAM change.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Reset values: FSM in IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, wait counter 0. RAM contents are not cleared by reset.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, capture we/byte/addr/wdata.
  - Next state is WAIT with counter=`WAIT_STATES`-1, or commit directly and go to RESP if `WAIT_STATES`=0.
- WAIT:
  - `req_ready`=0.
  - Counter decrements each cycle.
  - When counter is 0: commit the access and go to RESP.
- Commit rules:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - If addr ≥ 4·`DEPTH_WORDS`: `rsp_err`=1, no write, `rsp_rdata`=0.
  - Word load: `rsp_rdata`=RAM[index].
  - Word store: write all four lanes.
  - Byte load: lane addr[1:0], little-endian, zero-extended.
  - Byte store: write only lane addr[1:0].
  - Word access ignores addr[1:0] (without the config macro).
  - Stores return `rsp_rdata`=0.
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_err` stay stable until `rsp_valid`&`rsp_ready`.
  - On handshake, go to IDLE; `rsp_valid`, `rsp_rdata`, `rsp_err` return to 0.
  - `req_ready`=0, so no request is accepted in the handshake cycle.
- Reset mid-operation aborts to IDLE. A store whose commit edge has not occurred is never written; a committed store persists.

## Timing
- Request accepted at edge N: commit at edge N+`WAIT_STATES`; `rsp_valid` high from cycle N+1+`WAIT_STATES`.
- `WAIT_STATES`=0: `rsp_valid` high the cycle after accept.
- Minimum request spacing: `WAIT_STATES`+2 cycles, because IDLE is re-entered only after the response handshake.
- All outputs are registered; no combinational path from any input to any output.
- A load committed at edge N sees all stores committed at earlier edges.

## Configuration
- `DMEM_ALIGN_CHECK_EN`
  - Defined: word access with addr[1:0]≠0 sets `rsp_err`=1, with no write and `rsp_rdata`=0. The out-of-range check still applies.
  - Undefined: addr[1:0] is ignored for word access.
  - Byte access is unaffected either way.

## Structure
- `dmem_pkg`: state enum (IDLE/WAIT/RESP), `WORD_W`=32, `BYTE_LANES`=4, `DMEM_WAIT_MAX`=15.
- Sub-module `dmem_array`: synchronous RAM, `DEPTH_WORDS`×32, with 4-bit byte-lane write enable, single read/write port. The FSM, counter, and address decode live in `dmem_responder`.

## Test plan
- Word store 0xDEADBEEF @0x40, then word load @0x40 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` rises 3 cycles after accept (`WAIT_STATES`=2).
- Byte store 0xAA @0x41, then word load @0x40 → 0xDEADAAEF; byte load @0x43 → 0x000000DE.
- Word load @0x400 with `DEPTH_WORDS`=256 → `rsp_err`=1, `rsp_rdata`=0; word store @0x400 leaves RAM unchanged.
- Hold `rsp_ready`=0 for 3 cycles in RESP → `rsp_valid`/data stable and `req_ready`=0 throughout; the handshake returns the FSM to IDLE.
- Store 0x12345678 @0x80, assert `reset` in WAIT before commit; reload @0x80 → old contents, and all outputs hold reset values the cycle after reset.
- With `DMEM_ALIGN_CHECK_EN`: word store @0x42 → `rsp_err`=1, no write. Without it: same store writes word index 0x10.
